lsu_mio: RTL and testbench
==========================

Name: lsu_mio

Overview:
Parametrised load/store unit between the pipeline's memory stage and the memory/MMIO bus. It replaces the combinational load-extension and direct bus drive with a multi-cycle engine that:
- handles a bus ready handshake and stalls the pipeline while waiting;
- splits misaligned accesses into two aligned beats;
- generates byte enables and rotated write data;
- sign- or zero-extends load data;
- flags errors for illegal size, misaligned MMIO accesses and bus timeout.

Parameters:
XLEN, 32, data width; 32 or 64. B = XLEN/8 bytes per bus word.
ADDR_W, 32, address width.
MMIO_BASE, 32'hE000_0000, addresses >= this are MMIO.
TIMEOUT, 255, maximum cycles bus_req may wait for bus_ready; 8-bit counter minimum.

Ports:
clk  in  1  clock
reset  in  1  reset
req_valid  in  1  memory-stage access request; held until rsp_valid
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when XLEN=64)
req_unsigned  in  1  zero-extend load
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, LSB-aligned
stall  out  1  hold pipeline
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load data; 0 for stores
rsp_err  out  1  qualifies rsp_valid
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  ADDR_W  word-aligned address (low log2(B) bits 0)
bus_wdata  out  XLEN  rotated write data
bus_be  out  B  byte enables
bus_mio  out  1  bus_addr >= MMIO_BASE
bus_ready  in  1  bus accepts/completes beat in the same cycle
bus_rdata  in  XLEN  read data, valid when bus_ready

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: state IDLE; all outputs 0; captured request, beat-0 data and timeout counter cleared.
- Reset mid-operation: any state returns to IDLE at the next edge. bus_req drops; the outstanding beat is abandoned; no rsp_valid is issued.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE, req_valid=1:
  - stall=1 combinationally.
  - Capture the request: off = addr mod B, n = 1<<req_size bytes, split = (off+n > B).
  - Go to DONE with error if any of: req_size=11 and XLEN=32; (split and MMIO address); (req_size!=00 and MMIO address and off mod n != 0).
  - Otherwise go to BEAT0.
- IDLE, req_valid=0: stall=0.
- BEAT0:
  - bus_req=1, bus_we=req_we, bus_addr=addr with low bits cleared.
  - bus_be = (((1<<n)-1)<<off) truncated to B bits.
  - bus_wdata = req_wdata rotated left by 8*off.
  - On bus_ready: latch bus_rdata; go to BEAT1 if split, else DONE.
- BEAT1:
  - bus_addr = word address + B.
  - bus_be = remaining low bytes: ((1<<n)-1) >> (B-off).
  - bus_wdata is the same rotated data.
  - On bus_ready go to DONE.
- DONE:
  - rsp_valid=1 and stall=0 for exactly one cycle, then IDLE.
  - Load assembly: byte i of the result = byte (off+i) of beat0 if off+i < B, else byte (off+i-B) of beat1.
  - Extension: truncate the result to n bytes, then extend by req_unsigned (n=B: no extension).
- Timeout:
  - The counter resets on entry to each beat and increments per cycle that bus_req=1 and bus_ready=0.
  - When the count reaches TIMEOUT: abort, go to DONE with rsp_err=1, rsp_rdata=0. A write beat may already be partially committed; this is not retried.
- Latency: accept at cycle T, bus_req from T+1, rsp_valid at T+2+(wait cycles) for aligned accesses; one extra beat for split accesses.
- Back-to-back: after DONE the pipeline advances. A new req_valid seen in IDLE on the next cycle starts a new access. There is no IDLE-skip.
- bus_mio = bus_addr >= MMIO_BASE; 0 when bus_req=0.
- Outputs not covered above are 0: bus_* fields are 0 when bus_req=0; rsp_* fields are 0 when rsp_valid=0.

Test Plan:
1. XLEN=32, load word, addr 0x100, bus_ready immediate, rdata 0xDEADBEEF -> bus_be=1111 at T+1; rsp_valid at T+2; rsp_rdata=0xDEADBEEF; stall high T..T+1.
2. Load byte signed, addr 0x103, rdata 0x80_00_00_00 -> bus_be=1000; rsp_rdata=0xFFFFFF80. With req_unsigned=1 -> 0x00000080.
3. Store half, addr 0x203, wdata 0x0000ABCD -> beat0 addr 0x200, be=1000, wdata byte3=0xCD; beat1 addr 0x204, be=0001, byte0=0xAB; rsp_valid after beat1.
4. Load word, addr 0x102, beat0 rdata 0x1122_3344, beat1 rdata 0x5566_7788 -> rsp_rdata=0x7788_1122.
5. Load word at MMIO_BASE+1 -> no bus_req; rsp_valid+rsp_err at T+1. Size 11 with XLEN=32 -> same response.
6. TIMEOUT=4, bus_ready held 0 -> rsp_err after 4 wait cycles. Separately, reset asserted during BEAT0 -> bus_req=0 next cycle and no rsp_valid.

Source files
------------

// File: rtl/lsu_mio_if.sv
// lsu_mio_if: memory-stage request/response and memory/MMIO bus signals of the LSU.
// Ports: req_* / stall / rsp_* face the pipeline, bus_* face the memory/MMIO bus.
// Modports: slave = the LSU itself, master = pipeline plus bus agent driving it.
interface lsu_mio_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int B = XLEN / 8;

  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [B-1:0]      bus_be;
  logic              bus_mio;
  logic              bus_ready;
  logic [XLEN-1:0]   bus_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  bus_ready, bus_rdata,
    output stall, rsp_valid, rsp_rdata, rsp_err,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_mio
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output bus_ready, bus_rdata,
    input  stall, rsp_valid, rsp_rdata, rsp_err,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_mio
  );
endinterface

// File: rtl/lsu_mio.sv
// lsu_mio: multi-cycle load/store engine; splits misaligned accesses into two aligned
// beats, rotates store data, builds byte enables, extends loads, flags errors/timeouts.
// Latency: rsp_valid 2 cycles after accept plus bus wait cycles (+1 beat when split);
// stall is held from accept until the response cycle. Ports: clk, reset (sync, high), io.
module lsu_mio #(
  parameter int                XLEN      = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hE000_0000,
  parameter int                TIMEOUT   = 255
) (
  input  logic      clk,
  input  logic      reset,
  lsu_mio_if.slave  io
);
  localparam int B  = XLEN / 8;
  localparam int OW = $clog2(B);
  localparam int TW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t            state, nxt;
  logic              r_we, r_uns, r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, r_beat0, r_beat1;
  logic [TW-1:0]     tcnt;

  // Decode of the incoming request, used only for the IDLE accept decision.
  int   in_off, in_n;
  logic in_mmio, in_bad;
  assign in_off  = int'(io.req_addr[OW-1:0]);
  assign in_n    = 1 << io.req_size;
  assign in_mmio = io.req_addr >= MMIO_BASE;
  assign in_bad  = (io.req_size == 2'b11 && XLEN == 32) ||
                   (in_mmio && ((in_off + in_n > B) ||
                                (io.req_size != 2'b00 && (in_off % in_n) != 0)));

  // Geometry of the captured request.
  int                off_i, n_i;
  logic              split;
  logic [ADDR_W-1:0] word_addr, beat_addr;
  assign off_i     = int'(r_addr[OW-1:0]);
  assign n_i       = 1 << r_size;
  assign split     = (off_i + n_i) > B;
  assign word_addr = {r_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign beat_addr = (state == BEAT1) ? word_addr + ADDR_W'(B) : word_addr;

  // Bytes touched across the two-word window; low half is beat0, high half beat1.
  logic [2*B-1:0] be_full;
  always_comb begin
    be_full = '0;
    for (int i = 0; i < 2*B; i++) be_full[i] = (i >= off_i) && (i < off_i + n_i);
  end

  // Rotate-left of store data: upper half of the doubled word shifted by the offset.
  logic [2*XLEN-1:0] wd_dbl, rd_dbl;
  assign wd_dbl = {r_wdata, r_wdata} << (8 * off_i);
  // Load assembly: beat1 sits above beat0, so shifting down by the offset gathers bytes.
  assign rd_dbl = {r_beat1, r_beat0} >> (8 * off_i);

  logic [XLEN-1:0] ld_ext;
  always_comb begin
    ld_ext = rd_dbl[XLEN-1:0];
    for (int j = 0; j < XLEN; j++)
      if (j >= 8 * n_i) ld_ext[j] = r_uns ? 1'b0 : rd_dbl[8*n_i-1];
  end

  // Abort on the TIMEOUT-th consecutive wait cycle of a beat.
  logic to_hit;
  assign to_hit = !io.bus_ready && (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    nxt          = state;
    io.stall     = 1'b0;
    io.rsp_valid = 1'b0;
    io.rsp_rdata = '0;
    io.rsp_err   = 1'b0;
    io.bus_req   = 1'b0;
    io.bus_we    = 1'b0;
    io.bus_addr  = '0;
    io.bus_wdata = '0;
    io.bus_be    = '0;
    io.bus_mio   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          io.stall = io.req_valid;
          if (io.req_valid) nxt = in_bad ? DONE : BEAT0;
        end
        BEAT0, BEAT1: begin
          io.stall     = 1'b1;
          io.bus_req   = 1'b1;
          io.bus_we    = r_we;
          io.bus_addr  = beat_addr;
          io.bus_wdata = wd_dbl[2*XLEN-1:XLEN];
          io.bus_be    = (state == BEAT0) ? be_full[B-1:0] : be_full[2*B-1:B];
          io.bus_mio   = beat_addr >= MMIO_BASE;
          if (io.bus_ready) nxt = (state == BEAT0 && split) ? BEAT1 : DONE;
          else if (to_hit)  nxt = DONE;
        end
        DONE: begin
          io.rsp_valid = 1'b1;
          io.rsp_err   = r_err;
          io.rsp_rdata = (r_err || r_we) ? '0 : ld_ext;
          nxt          = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_beat0 <= '0;
      r_beat1 <= '0;
      tcnt    <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (io.req_valid) begin
            r_we    <= io.req_we;
            r_uns   <= io.req_unsigned;
            r_size  <= io.req_size;
            r_addr  <= io.req_addr;
            r_wdata <= io.req_wdata;
            r_err   <= in_bad;
            r_beat0 <= '0;
            r_beat1 <= '0;
          end
        end
        BEAT0, BEAT1: begin
          if (io.bus_ready) begin
            tcnt <= '0;
            if (state == BEAT0) r_beat0 <= io.bus_rdata;
            else                r_beat1 <= io.bus_rdata;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (to_hit) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mio.sv
module tb_lsu_mio;
  localparam int          XLEN = 32;
  localparam int          AW   = 32;
  localparam int          TO   = 4;
  localparam logic [31:0] MMIO = 32'hE000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_mio_if #(.XLEN(XLEN), .ADDR_W(AW)) bif ();
  lsu_mio #(.XLEN(XLEN), .ADDR_W(AW), .MMIO_BASE(MMIO), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .io(bif.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] bus_mem [logic [31:0]];  // what the DUT actually wrote over the bus
  logic [7:0] ref_mem [logic [31:0]];  // what memory should contain
  logic [31:0] got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bus_byte(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
  endfunction
  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction
  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    bus_mem[a] = d;
    ref_mem[a] = d;
  endtask
  task automatic poke_word(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) poke(a + 32'(i), d[8*i +: 8]);
  endtask

  // Reference: read n little-endian bytes from memory, then extend.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(addr + 32'(i));
    if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    int n, off;
    n   = 1 << size;
    off = int'(addr[1:0]);
    if (size == 2'b11) return 1'b1;
    return (addr >= MMIO) && ((off + n > 4) || (off % n != 0));
  endfunction

  // One access: drives the request and plays the bus, w0/w1 = wait cycles per beat.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int w0, input int w1, output logic [31:0] rdata);
    int n, nbeats, exp_cyc, beat, wcnt;
    logic split, exp_err, to, done;
    logic [31:0] exp_data, wa;
    logic [3:0] exp_be;
    n       = 1 << size;
    split   = (int'(addr[1:0]) + n) > 4;
    exp_err = model_err(size, addr);
    to      = 1'b0;
    if (exp_err) begin
      nbeats = 0; exp_cyc = 1;
    end else if (w0 >= TO) begin
      to = 1'b1; nbeats = 0; exp_cyc = 1 + TO;
    end else if (split && w1 >= TO) begin
      to = 1'b1; nbeats = 1; exp_cyc = 1 + (w0 + 1) + TO;
    end else begin
      nbeats  = split ? 2 : 1;
      exp_cyc = 1 + (w0 + 1) + (split ? (w1 + 1) : 0);
    end
    exp_data = (exp_err || to || we) ? 32'h0 : model_load(size, uns, addr);
    if (we && !exp_err && !to)
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];

    @(negedge clk);
    check("rsp_single_cycle", bif.rsp_valid, 1'b0);
    bif.req_valid = 1'b1; bif.req_we = we; bif.req_size = size;
    bif.req_unsigned = uns; bif.req_addr = addr; bif.req_wdata = wdata;
    bif.bus_ready = 1'b0;
    #1 check("stall_accept", bif.stall, 1'b1);
    beat = 0; wcnt = 0; done = 1'b0; rdata = '0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      bif.bus_ready = 1'b0;
      bif.bus_rdata = $urandom;
      if (bif.rsp_valid) begin
        done = 1'b1;
        check("rsp_cycle", cyc, exp_cyc);
        check("rsp_err", bif.rsp_err, exp_err || to);
        check("rsp_rdata", bif.rsp_rdata, exp_data);
        check("stall_at_rsp", bif.stall, 1'b0);
        check("beats", beat, nbeats);
        check("bus_idle_at_rsp", {bif.bus_req, bif.bus_be, bif.bus_addr}, '0);
        rdata = bif.rsp_rdata;
        bif.req_valid = 1'b0;
      end else begin
        check("stall_busy", bif.stall, 1'b1);
        check("bus_req_busy", bif.bus_req, 1'b1);
        if (bif.bus_req) begin
          if (wcnt < ((beat == 0) ? w0 : w1)) wcnt++;
          else begin
            wa = (addr & ~32'd3) + 32'(4 * beat);
            for (int j = 0; j < 4; j++)
              exp_be[j] = (wa + 32'(j) >= addr) && (wa + 32'(j) < addr + 32'(n));
            check("bus_addr", bif.bus_addr, wa);
            check("bus_be", bif.bus_be, exp_be);
            check("bus_we", bif.bus_we, we);
            check("bus_mio", bif.bus_mio, wa >= MMIO);
            bif.bus_ready = 1'b1;
            bif.bus_rdata = {bus_byte(wa + 3), bus_byte(wa + 2), bus_byte(wa + 1), bus_byte(wa)};
            if (we)
              for (int j = 0; j < 4; j++)
                if (bif.bus_be[j]) bus_mem[wa + 32'(j)] = bif.bus_wdata[8*j +: 8];
            beat++;
            wcnt = 0;
          end
        end
      end
    end
    bif.bus_ready = 1'b0;
    if (!done) begin
      check("rsp_never_arrived", 1'b0, 1'b1);
      bif.req_valid = 1'b0;
    end
    if (we && !exp_err)
      for (int k = -4; k < 8; k++) check("mem", bus_byte(addr + 32'(k)), ref_byte(addr + 32'(k)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    int          w0, w1, r;

    reset = 1'b1;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_size = 2'b00; bif.req_unsigned = 1'b0;
    bif.req_addr = '0; bif.req_wdata = '0; bif.bus_ready = 1'b0; bif.bus_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bif.stall, bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.bus_req, bif.bus_we, bif.bus_be, bif.bus_mio},
          '0);
    check("reset_bus_addr", bif.bus_addr, '0);
    reset = 1'b0;

    // Aligned load word, immediate ready.
    poke_word(32'h100, 32'hDEAD_BEEF);
    access(1'b0, 2'b10, 1'b0, 32'h100, '0, 0, 0, got);
    check("ld_word", got, 32'hDEAD_BEEF);
    // Byte loads at the top byte lane, signed and unsigned.
    poke_word(32'h100, 32'h8000_0000);
    access(1'b0, 2'b00, 1'b0, 32'h103, '0, 0, 0, got);
    check("ld_byte_signed", got, 32'hFFFF_FF80);
    access(1'b0, 2'b00, 1'b1, 32'h103, '0, 1, 0, got);
    check("ld_byte_unsigned", got, 32'h0000_0080);
    // Split store half.
    access(1'b1, 2'b01, 1'b0, 32'h203, 32'h0000_ABCD, 0, 0, got);
    check("st_split_lo", bus_byte(32'h203), 8'hCD);
    check("st_split_hi", bus_byte(32'h204), 8'hAB);
    // Split load word.
    poke_word(32'h100, 32'h1122_3344);
    poke_word(32'h104, 32'h5566_7788);
    access(1'b0, 2'b10, 1'b0, 32'h102, '0, 0, 2, got);
    check("ld_split_word", got, 32'h7788_1122);
    // Error responses without any bus activity.
    access(1'b0, 2'b10, 1'b0, MMIO + 32'd1, '0, 0, 0, got);
    access(1'b0, 2'b11, 1'b0, 32'h100, '0, 0, 0, got);
    access(1'b1, 2'b01, 1'b0, MMIO + 32'd1, 32'h1234, 0, 0, got);
    // Aligned MMIO half store is legal.
    access(1'b1, 2'b01, 1'b0, MMIO + 32'd2, 32'h0000_5A5A, 0, 0, got);
    // Timeouts on beat0 and on beat1.
    access(1'b0, 2'b10, 1'b0, 32'h100, '0, 100, 0, got);
    access(1'b0, 2'b10, 1'b0, 32'h102, '0, 1, 100, got);
    // Just under the timeout limit still completes.
    access(1'b0, 2'b10, 1'b0, 32'h104, '0, TO - 1, 0, got);
    check("ld_max_wait", got, 32'h5566_7788);

    // Reset while BEAT0 is waiting.
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_size = 2'b10; bif.req_addr = 32'h100;
    bif.bus_ready = 1'b0;
    @(negedge clk);
    check("beat0_before_reset", bif.bus_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    bif.req_valid = 1'b0;
    check("reset_mid_bus_req", bif.bus_req, 1'b0);
    check("reset_mid_rsp", bif.rsp_valid, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", {bif.rsp_valid, bif.bus_req, bif.stall}, 3'b000);
    end

    // Randomized accesses against the byte-level memory model.
    for (int a = 0; a < 128; a++) poke(32'h1000 + 32'(a), 8'($urandom));
    for (int t = 0; t < 120; t++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      r     = $urandom_range(0, 9);
      size  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      addr  = ($urandom_range(0, 5) == 0) ? MMIO + 32'($urandom_range(0, 15))
                                          : 32'h1000 + 32'($urandom_range(0, 63));
      wdata = $urandom;
      w0    = $urandom_range(0, TO - 1);
      w1    = $urandom_range(0, TO - 1);
      if (!we && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) w0 = TO + 1;
        else                           w1 = TO + 1;
      end
      access(we, size, uns, addr, wdata, w0, w1, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
